// File: rtl/lsu_unit_if.sv
// Load/store unit handshake bundle: execute-side request/response and memory bus.
// The slave modport is the LSU; the master modport is its environment.
interface lsu_unit_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit: one aligned 64-bit handshaked bus access per op,
// with lane steering for stores and sign/zero extension for loads.
module lsu_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic        clk,
    input logic        rst_n,
    lsu_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_n;

    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic              err_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              mwe_q;
    logic [7:0]        mstrb_q;
    logic [DATA_W-1:0] mwdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              mis;
    logic [7:0]        smask;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ext;

    always_comb begin
        mis   = 1'b0;
        smask = 8'h01;
        unique case (bus.req_size)
            2'd0: begin mis = 1'b0;                    smask = 8'h01; end
            2'd1: begin mis = bus.req_addr[0];         smask = 8'h03; end
            2'd2: begin mis = |bus.req_addr[1:0];      smask = 8'h0F; end
            2'd3: begin mis = |bus.req_addr[2:0];      smask = 8'hFF; end
            default: ;
        endcase
    end

    // Right-align the addressed lanes before truncating and extending.
    always_comb begin
        sh  = bus.mem_rdata >> {off_q, 3'b000};
        ext = sh;
        unique case (size_q)
            2'd0: ext = uns_q ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1: ext = uns_q ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2: ext = uns_q ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            2'd3: ext = sh;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.req_valid) state_n = mis ? RESP : REQ;
            REQ:  if (bus.mem_req_ready) state_n = WAIT;
            WAIT: if (bus.mem_rsp_valid) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off_q    <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            maddr_q  <= '0;
            mwe_q    <= 1'b0;
            mstrb_q  <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                off_q    <= bus.req_addr[2:0];
                size_q   <= bus.req_size;
                we_q     <= bus.req_we;
                uns_q    <= bus.req_unsigned;
                err_q    <= mis;
                maddr_q  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
                mwe_q    <= bus.req_we & ~mis;
                mstrb_q  <= (bus.req_we && !mis) ? 8'(smask << bus.req_addr[2:0]) : 8'h00;
                mwdata_q <= bus.req_we ? bus.req_wdata << {bus.req_addr[2:0], 3'b000} : '0;
                rdata_q  <= '0;
            end
            if (state == WAIT && bus.mem_rsp_valid && !we_q) rdata_q <= ext;
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_addr      = maddr_q;
    assign bus.mem_we        = mwe_q;
    assign bus.mem_wstrb     = mstrb_q;
    assign bus.mem_wdata     = mwdata_q;
    assign bus.resp_valid    = (state == RESP);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;
endmodule

// File: tb/tb_lsu_unit.sv
// Randomized bench for lsu_unit with an in-bench byte-level reference model.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_lsu_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    lsu_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    lsu_unit #(.ADDR_W(64), .DATA_W(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off,
                                             input int size, input logic uns);
        logic [63:0] r;
        int nb;
        nb = 1 << size;
        r = '0;
        for (int b = 0; b < nb; b++) r[8*b +: 8] = rd[8*(off+b) +: 8];
        if (!uns && nb < 8 && r[8*nb-1])
            for (int b = nb; b < 8; b++) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.req_valid     = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'($urandom) << 32 | 64'($urandom);
    endtask

    // Issue one op and play the bus side with the given delays.
    task automatic do_op(input logic [63:0] addr, input logic we, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata, input logic [63:0] rdata,
                         input int rdy_dly, input int rsp_dly, input logic intrude,
                         input logic chk_lat);
        int nb, off, cyc, pulses;
        logic mis;
        logic [7:0] estrb;
        logic [63:0] lmask, ewd, eaddr;
        nb  = 1 << size;
        off = int'(addr[2:0]);
        mis = (addr % 64'(nb)) != 0;
        eaddr = addr & ~64'h7;
        estrb = '0;
        lmask = '0;
        ewd   = '0;
        for (int b = 0; b < nb; b++) begin
            if (!mis) begin
                estrb[off+b] = we;
                lmask[8*(off+b) +: 8] = 8'hFF;
                ewd[8*(off+b) +: 8] = wdata[8*b +: 8];
            end
        end
        @(negedge clk);
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 1;
        pulses = 0;
        if (mis) begin
            check("mis_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("mis_resp_err", 64'(bus.resp_err), 64'd1);
            check("mis_no_memreq", 64'(bus.mem_req_valid), 64'd0);
            check("mis_rdata", bus.resp_rdata, 64'd0);
            @(negedge clk);
            check("mis_pulse_end", 64'(bus.resp_valid), 64'd0);
            check("mis_no_memreq2", 64'(bus.mem_req_valid), 64'd0);
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            check("req_valid", 64'(bus.mem_req_valid), 64'd1);
            check("mem_addr", bus.mem_addr, eaddr);
            check("mem_we", 64'(bus.mem_we), 64'(we));
            check("mem_wstrb", 64'(bus.mem_wstrb), 64'(estrb));
            if (we) check("mem_wdata", bus.mem_wdata & lmask, ewd);
            if (bus.resp_valid) pulses++;
            bus.mem_req_ready = (k == rdy_dly);
            bus.mem_rsp_valid = (k < rdy_dly) ? 1'($urandom_range(1)) : 1'b0;
            bus.req_valid = intrude && k == 1;
            bus.req_addr  = 64'h0000_0000_1234_5678;
            if (intrude && k == 1) check("busy_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
            cyc++;
        end
        bus.mem_req_ready = 1'b0;
        bus.req_valid = 1'b0;
        for (int k = 0; k <= rsp_dly; k++) begin
            check("wait_no_memreq", 64'(bus.mem_req_valid), 64'd0);
            if (bus.resp_valid) pulses++;
            bus.mem_rsp_valid = (k == rsp_dly);
            bus.mem_rdata = (k == rsp_dly) ? rdata : 64'($urandom);
            @(negedge clk);
            cyc++;
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata = 64'($urandom);
        check("resp_valid", 64'(bus.resp_valid), 64'd1);
        check("resp_err", 64'(bus.resp_err), 64'd0);
        check("resp_rdata", bus.resp_rdata, we ? 64'd0 : ref_load(rdata, off, int'(size), uns));
        if (chk_lat) check("latency", 64'(cyc), 64'd3);
        @(negedge clk);
        check("pulse_end", 64'(bus.resp_valid), 64'd0);
        check("back_idle", 64'(bus.req_ready), 64'd1);
        check("extra_pulses", 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [63:0] a, wd, rd;
        logic [1:0] sz;
        idle_inputs();
        bus.req_addr = '0;
        bus.req_we = 1'b0;
        bus.req_size = '0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_memreq", 64'(bus.mem_req_valid), 64'd0);
        check("rst_resp", 64'(bus.resp_valid), 64'd0);
        check("rst_err", 64'(bus.resp_err), 64'd0);
        check("rst_addr", bus.mem_addr, 64'd0);
        check("rst_wdata", bus.mem_wdata, 64'd0);
        check("rst_strb", 64'(bus.mem_wstrb), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_rdata", bus.resp_rdata, 64'd0);
        rst_n = 1'b1;

        do_op(64'h8000_0003, 1'b0, 2'd0, 1'b0, '0, 64'h1122_3344_AABB_CCDD, 0, 0, 1'b0, 1'b1);
        do_op(64'h8000_0004, 1'b0, 2'd2, 1'b1, '0, 64'h8765_4321_0000_0000, 0, 0, 1'b0, 1'b1);
        do_op(64'h8000_0004, 1'b0, 2'd2, 1'b0, '0, 64'h8765_4321_0000_0000, 0, 0, 1'b0, 1'b1);
        do_op(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'hBEEF, '0, 0, 0, 1'b0, 1'b1);
        do_op(64'h8000_0002, 1'b0, 2'd2, 1'b0, '0, '0, 0, 0, 1'b0, 1'b0);
        do_op(64'h8000_0010, 1'b0, 2'd3, 1'b1, '0, 64'hF00D_CAFE_1234_5678, 5, 3, 1'b1, 1'b0);

        // Reset while waiting for the bus response, then a stale response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = 64'h8000_0020;
        bus.req_we = 1'b0;
        bus.req_size = 2'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_memreq", 64'(bus.mem_req_valid), 64'd0);
        check("rstmid_ready", 64'(bus.req_ready), 64'd1);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rstmid_noresp", 64'(bus.resp_valid), 64'd0);
            check("rstmid_idle", 64'(bus.req_ready), 64'd1);
            @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(3));
            a  = 64'h8000_0000 | 64'($urandom_range(255));
            if ($urandom_range(3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {32'($urandom), 32'($urandom)};
            rd = {32'($urandom), 32'($urandom)};
            do_op(a, 1'($urandom_range(1)), sz, 1'($urandom_range(1)), wd, rd,
                  $urandom_range(3), $urandom_range(3), 1'($urandom_range(1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
